wb_timer: RTL and testbench
===========================

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter BASE, default 0: 12-bit block select, compared against adr_i[14:3].
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 arst  input  1  reset, asynchronous, active-high.
REQ-004 adr_i  input  15  Wishbone word address from the MCU's Wishbone master.
REQ-005 dat_i  input  32  Wishbone write data.
REQ-006 we_i  input  1  Wishbone write enable.
REQ-007 stb_i  input  1  Wishbone strobe.
REQ-008 dat_o  output  32  Wishbone read data, valid while ack_o is high.
REQ-009 ack_o  output  1  Wishbone acknowledge.
REQ-010 cap_i  input  1  capture request, already synchronous to clk.
REQ-011 irq  output  1  level interrupt request to the MCU ipending logic.

Function
REQ-012 The block SHALL be selected when adr_i[14:3]==BASE; unselected strobes are still acked, with reads returning 0 and writes ignored.
REQ-013 The register map SHALL be offset adr_i[2:0]: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, 4 CAPTURE (read-only); offsets 5-7 read 0 and ignore writes.
REQ-014 CTRL bits SHALL be: [0] EN, [1] AUTORELOAD, [2] IE, [31:16] PRESCALE; bits [15:3] SHALL read 0.
REQ-015 ack_o SHALL register (stb_i & ~ack_o), giving a one-cycle ack one cycle after strobe; a held stb_i acks every second cycle.
REQ-016 A write SHALL commit, and dat_o SHALL load, on the edge where ack_o rises; dat_o SHALL hold its value otherwise.
REQ-017 The prescaler counter SHALL count 0..PRESCALE and emit a tick on the cycle it equals PRESCALE, then return to 0; PRESCALE=0 SHALL give a tick every cycle.
REQ-018 The prescaler SHALL be held at 0 while EN=0 and cleared on any CTRL write.
REQ-019 On a tick with EN=1, if COUNT==COMPARE, STATUS.MATCH[0] SHALL set and COUNT SHALL become 0 when AUTORELOAD=1, else COUNT+1.
REQ-020 Otherwise, on a tick with EN=1, COUNT SHALL increment modulo 2^32; the 0xFFFFFFFF->0 wrap SHALL set STATUS.OVF[1].
REQ-021 A rising edge of cap_i (cap_i=1, previous=0) SHALL load CAPTURE with the current COUNT and set STATUS.CAP[2].
REQ-022 STATUS bits SHALL be sticky, write-1-to-clear; a set event in the same cycle as a clear SHALL win.
REQ-023 A bus write to COUNT SHALL override a same-cycle increment or reload.
REQ-024 irq SHALL be registered as IE & (MATCH | OVF | CAP).

Reset
REQ-025 While arst=1, every register (CTRL, COUNT, COMPARE, STATUS, CAPTURE, prescaler, cap_i edge flop) SHALL be 0, and ack_o, dat_o and irq SHALL be 0.
REQ-026 arst asserted mid-transfer SHALL abort it: no write commits and no ack is issued.
REQ-027 After release, the first ack SHALL occur one cycle after stb_i is sampled.

Structure
REQ-028 Package wb_timer_pkg SHALL hold the register offsets, CTRL/STATUS bit positions, and data width (32) and address width (15) constants.
REQ-029 The prescaler SHALL be a sub-module, wb_timer_prescale (inputs: PRESCALE, enable, clear; output: tick).
REQ-030 The block SHALL drop into the MCU in place of the Wishbone loopback, with irq wired to ipending[4].

Verification
REQ-031 Reset then read offsets 0-7 -> all return 0; ack_o pulses once per access, one cycle after stb_i.
REQ-032 PRESCALE=3, EN=1, COMPARE=5, AUTORELOAD=1 -> COUNT advances every 4 cycles, goes 0..5, then 0; MATCH sets on the 5->0 tick.
REQ-033 Write COUNT=0xFFFFFFFE with PRESCALE=0, EN=1 -> after 2 cycles COUNT=0 and OVF=1; irq=1 only if IE=1.
REQ-034 Write STATUS=0x1 in the same cycle as a match tick -> MATCH remains 1; a later write of 0x1 with no tick -> MATCH=0 and irq drops next cycle.
REQ-035 Pulse cap_i with COUNT=0x1234 -> CAPTURE=0x1234 and CAP=1; holding cap_i high causes no further captures.
REQ-036 Assert arst during a write strobe to COMPARE=0xAA -> COMPARE stays 0 and no ack is issued.

Source files
------------

// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the Wishbone timer: bus widths, register
// offsets, CTRL/STATUS bit positions and the CTRL register layout.
package wb_timer_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 15;
    localparam int SEL_W      = 12;
    localparam int PRESCALE_W = 16;
    localparam int STATUS_W   = 3;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COUNT   = 3'd1;
    localparam logic [2:0] REG_COMPARE = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IE         = 2;
    localparam int CTRL_PRESCALE   = 16;

    localparam int ST_MATCH = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_CAP   = 2;

    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  ie;
        logic                  autoreload;
        logic                  en;
    } ctrl_t;

    // Bits [15:3] have no storage and always read back as zero.
    function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_EN]         = c.en;
        w[CTRL_AUTORELOAD] = c.autoreload;
        w[CTRL_IE]         = c.ie;
        w[CTRL_PRESCALE +: PRESCALE_W] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/wb_timer_prescale.sv
// Prescaler: counts 0..prescale and ticks on the cycle the count equals
// prescale; held at zero while disabled or being cleared.
module wb_timer_prescale
    import wb_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  enable,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_p1;

    assign tick = enable && (cnt_p1 == prescale);

    // prescale only changes through a CTRL write, which also clears the count,
    // so cnt_p1 can never be left above a newly lowered prescale.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_p1 <= '0;
        end else if (clear || !enable || tick) begin
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer/counter with prescaler, compare match with optional
// auto-reload, overflow flag, input capture and a level interrupt.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [SEL_W-1:0] BASE = '0
)
(
    input  logic              clk,
    input  logic              arst,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              we_i,
    input  logic              stb_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    input  logic              cap_i,
    output logic              irq
);

    ctrl_t                 ctrl;
    logic [DATA_W-1:0]     count;
    logic [DATA_W-1:0]     compare;
    logic [DATA_W-1:0]     capture;
    logic [STATUS_W-1:0]   status;
    logic                  cap_i_p1;

    logic                  sel;
    logic [2:0]            off;
    logic                  acc;
    logic                  wr;
    logic                  wr_ctrl;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_status;
    logic                  tick;
    logic                  hit;
    logic                  wrap;
    logic                  cap_evt;
    logic [STATUS_W-1:0]   status_set;
    logic [STATUS_W-1:0]   status_clr;
    logic [DATA_W-1:0]     count_nxt;
    logic [DATA_W-1:0]     rdata;

    assign sel = (adr_i[ADDR_W-1:3] == BASE);
    assign off = adr_i[2:0];

    // An access is taken on the cycle ack_o rises; a held strobe re-arms after it.
    assign acc        = stb_i & ~ack_o;
    assign wr         = acc & we_i & sel;
    assign wr_ctrl    = wr && (off == REG_CTRL);
    assign wr_count   = wr && (off == REG_COUNT);
    assign wr_compare = wr && (off == REG_COMPARE);
    assign wr_status  = wr && (off == REG_STATUS);

    wb_timer_prescale u_prescale (
        .clk      (clk),
        .arst     (arst),
        .prescale (ctrl.prescale),
        .enable   (ctrl.en),
        .clear    (wr_ctrl),
        .tick     (tick)
    );

    assign hit     = tick && (count == compare);
    assign wrap    = tick && !hit && (&count);
    assign cap_evt = cap_i & ~cap_i_p1;

    always_comb begin
        status_set           = '0;
        status_set[ST_MATCH] = hit;
        status_set[ST_OVF]   = wrap;
        status_set[ST_CAP]   = cap_evt;
        status_clr           = wr_status ? dat_i[STATUS_W-1:0] : '0;
    end

    // A bus write to COUNT takes priority over the tick update.
    always_comb begin
        count_nxt = count;
        if (wr_count) begin
            count_nxt = dat_i;
        end else if (hit) begin
            count_nxt = ctrl.autoreload ? '0 : count + 32'd1;
        end else if (tick) begin
            count_nxt = count + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            REG_CTRL:    rdata = ctrl_to_word(ctrl);
            REG_COUNT:   rdata = count;
            REG_COMPARE: rdata = compare;
            REG_STATUS:  rdata = {{(DATA_W-STATUS_W){1'b0}}, status};
            REG_CAPTURE: rdata = capture;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ack_o    <= 1'b0;
            dat_o    <= '0;
            ctrl     <= '0;
            count    <= '0;
            compare  <= '0;
            capture  <= '0;
            status   <= '0;
            cap_i_p1 <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ack_o <= acc;
            if (acc) begin
                dat_o <= sel ? rdata : '0;
            end
            if (wr_ctrl) begin
                ctrl.prescale   <= dat_i[CTRL_PRESCALE +: PRESCALE_W];
                ctrl.ie         <= dat_i[CTRL_IE];
                ctrl.autoreload <= dat_i[CTRL_AUTORELOAD];
                ctrl.en         <= dat_i[CTRL_EN];
            end
            if (wr_compare) begin
                compare <= dat_i;
            end
            count <= count_nxt;
            // Set beats a same-cycle write-1-to-clear.
            status <= (status & ~status_clr) | status_set;
            if (cap_evt) begin
                capture <= count;
            end
            cap_i_p1 <= cap_i;
            irq      <= ctrl.ie & (|status);
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: bus timing, register map, prescaled counting,
// match/overflow/capture flags, write-1-to-clear, irq and reset abort.
module tb_wb_timer;
    import wb_timer_pkg::*;

    logic        clk = 1'b0;
    logic        arst;
    logic [14:0] adr_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        cap_i;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_timer dut (
        .clk   (clk),
        .arst  (arst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .we_i  (we_i),
        .stb_i (stb_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .cap_i (cap_i),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wb_write(input logic [2:0] off, input logic [31:0] d,
                            input logic [11:0] blk = 12'h000);
        adr_i = {blk, off};
        dat_i = d;
        we_i  = 1'b1;
        stb_i = 1'b1;
        @(negedge clk);
        chk("wr_ack", 32'(ack_o), 32'd1);
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk);
        chk("wr_ack_drop", 32'(ack_o), 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [2:0] off, input logic [31:0] exp,
                            input logic [11:0] blk = 12'h000);
        adr_i = {blk, off};
        we_i  = 1'b0;
        stb_i = 1'b1;
        @(negedge clk);
        chk("rd_ack", 32'(ack_o), 32'd1);
        chk(tag, dat_o, exp);
        stb_i = 1'b0;
        @(negedge clk);
        chk("rd_ack_drop", 32'(ack_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        arst  = 1'b1;
        adr_i = '0;
        dat_i = '0;
        we_i  = 1'b0;
        stb_i = 1'b0;
        cap_i = 1'b0;
        idle(2);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        arst = 1'b0;
        idle(1);

        // Reset values of the whole map
        for (int i = 0; i < 8; i++) read_chk("rst_reg", 3'(i), 32'd0);

        // Held strobe: ack on every second cycle
        adr_i = 15'd0;
        stb_i = 1'b1;
        @(negedge clk); chk("held_ack0", 32'(ack_o), 32'd1);
        @(negedge clk); chk("held_ack1", 32'(ack_o), 32'd0);
        @(negedge clk); chk("held_ack2", 32'(ack_o), 32'd1);
        @(negedge clk); chk("held_ack3", 32'(ack_o), 32'd0);
        stb_i = 1'b0;
        idle(1);

        // CTRL readback masks the unimplemented bits
        wb_write(REG_CTRL, 32'h0003_FFF8);
        read_chk("ctrl_rb", REG_CTRL, 32'h0003_0000);
        wb_write(REG_CTRL, 32'h0);

        // PRESCALE=3, COMPARE=5, autoreload: count 0..5 then 0, every 4 cycles
        wb_write(REG_COMPARE, 32'd5);
        wb_write(REG_COUNT, 32'd0);
        wb_write(REG_CTRL, 32'h0003_0003);
        for (int k = 0; k < 6; k++) begin
            read_chk("pre_count", REG_COUNT, 32'(k));
            idle(2);
        end
        read_chk("reload_count", REG_COUNT, 32'd0);
        idle(2);
        read_chk("match_flag", REG_STATUS, 32'h1);
        wb_write(REG_CTRL, 32'h0);
        wb_write(REG_STATUS, 32'h7);
        read_chk("status_w1c", REG_STATUS, 32'h0);

        // Overflow wrap with PRESCALE=0; irq gated by IE
        wb_write(REG_COUNT, 32'hFFFF_FFFE);
        wb_write(REG_CTRL, 32'h1);
        wb_write(REG_CTRL, 32'h0);
        read_chk("wrap_count", REG_COUNT, 32'h0);
        read_chk("ovf_flag", REG_STATUS, 32'h2);
        chk("irq_ie0", 32'(irq), 32'd0);
        wb_write(REG_CTRL, 32'h4);
        chk("irq_ovf", 32'(irq), 32'd1);
        wb_write(REG_STATUS, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);

        // Clear of MATCH in the same cycle as a match tick: set wins
        wb_write(REG_CTRL, 32'h0);
        wb_write(REG_COMPARE, 32'd3);
        wb_write(REG_COUNT, 32'd3);
        wb_write(REG_CTRL, 32'h7);
        idle(3);
        wb_write(REG_STATUS, 32'h1);
        wb_write(REG_CTRL, 32'h4);
        chk("irq_match", 32'(irq), 32'd1);
        read_chk("match_kept", REG_STATUS, 32'h1);
        adr_i = {12'h000, REG_STATUS};
        dat_i = 32'h1;
        we_i  = 1'b1;
        stb_i = 1'b1;
        @(negedge clk);
        chk("irq_lag", 32'(irq), 32'd1);
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk);
        chk("irq_drop", 32'(irq), 32'd0);
        read_chk("match_clr", REG_STATUS, 32'h0);

        // Capture on a rising edge of cap_i only
        wb_write(REG_CTRL, 32'h0);
        wb_write(REG_COUNT, 32'h1234);
        cap_i = 1'b1;
        @(negedge clk);
        cap_i = 1'b0;
        read_chk("capture", REG_CAPTURE, 32'h1234);
        read_chk("cap_flag", REG_STATUS, 32'h4);
        wb_write(REG_STATUS, 32'h4);
        wb_write(REG_COUNT, 32'h5555);
        cap_i = 1'b1;
        idle(2);
        wb_write(REG_STATUS, 32'h4);
        wb_write(REG_COUNT, 32'h7777);
        idle(2);
        read_chk("cap_held", REG_CAPTURE, 32'h5555);
        read_chk("cap_held_flag", REG_STATUS, 32'h0);
        cap_i = 1'b0;
        idle(1);

        // Unselected block: acked, write ignored, read returns 0
        wb_write(REG_COMPARE, 32'h99, 12'h001);
        read_chk("unsel_rd", REG_COMPARE, 32'h0, 12'h001);
        read_chk("compare_kept", REG_COMPARE, 32'd3);

        // Reset in the middle of a COMPARE write aborts it
        adr_i = {12'h000, REG_COMPARE};
        dat_i = 32'hAA;
        we_i  = 1'b1;
        stb_i = 1'b1;
        #2 arst = 1'b1;
        @(negedge clk);
        chk("abort_ack", 32'(ack_o), 32'd0);
        chk("abort_dat", dat_o, 32'd0);
        chk("abort_irq", 32'(irq), 32'd0);
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        idle(1);
        read_chk("abort_compare", REG_COMPARE, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
